// File: rtl/normshift_pkg.sv
// Shared constants for the multi-cycle left-shift normalizer.
package normshift_pkg;

  localparam int NS_WIDTH = 23;
  localparam int NS_STEP  = 4;

endpackage

// File: rtl/normshift_step.sv
// One bounded shift step: left shift by 0..STEP bits, zero fill, and OR of
// the bits pushed out of the MSB.
module normshift_step
  import normshift_pkg::*;
#(
  parameter int WIDTH = NS_WIDTH,
  parameter int STEP  = NS_STEP
) (
  input  logic [WIDTH-1:0]             i_data,
  input  logic [$clog2(STEP+1)-1:0]    i_sh,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_lost
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] w_keep_mask;

  // Bits that survive the shift sit below the top i_sh positions.
  assign w_keep_mask = ALL_ONES >> i_sh;
  assign o_data      = i_data << i_sh;
  assign o_lost      = |(i_data & ~w_keep_mask);

endmodule

// File: rtl/normshift.sv
// Multi-cycle left-shift normalizer: shifts an operand by up to STEP bits per
// cycle between two valid/ready handshakes and reports any lost 1 bits.
module normshift
  import normshift_pkg::*;
#(
  parameter int WIDTH = NS_WIDTH,
  parameter int STEP  = NS_STEP
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          Flush,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic [WIDTH-1:0]              InNum,
  input  logic [$clog2(WIDTH+1)-1:0]    InShAmt,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic [WIDTH-1:0]              OutNum,
  output logic                          OutLost
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(STEP + 1);
  localparam logic [CW-1:0] CLAMP    = CW'(WIDTH);
  localparam logic [CW-1:0] STEP_MAX = CW'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_data,  w_next_data;
  logic [CW-1:0]    r_rem,   w_next_rem;
  logic             r_lost,  w_next_lost;

  logic [CW-1:0]    w_in_rem;
  logic [CW-1:0]    w_s_full;
  logic [SW-1:0]    w_s;
  logic [WIDTH-1:0] w_sh_data;
  logic             w_sh_lost;
  logic             w_accept;

  assign w_in_rem = (InShAmt > CLAMP) ? CLAMP : InShAmt;
  assign w_s_full = (r_rem > STEP_MAX) ? STEP_MAX : r_rem;
  assign w_s      = w_s_full[SW-1:0];

  normshift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_data (r_data),
    .i_sh   (w_s),
    .o_data (w_sh_data),
    .o_lost (w_sh_lost)
  );

  // Handshake flags depend only on state and OutReady.
  assign InReady  = (r_state == S_IDLE) || ((r_state == S_DONE) && OutReady);
  assign OutValid = (r_state == S_DONE);
  assign OutNum   = r_data;
  assign OutLost  = r_lost;
  assign w_accept = InValid && InReady;

  // Next-state and datapath update; Flush overrides every handshake.
  always_comb begin
    w_next_state = r_state;
    w_next_data  = r_data;
    w_next_rem   = r_rem;
    w_next_lost  = r_lost;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_next_data  = InNum;
          w_next_rem   = w_in_rem;
          w_next_lost  = 1'b0;
          w_next_state = (w_in_rem == {CW{1'b0}}) ? S_DONE : S_SHIFT;
        end else if ((r_state == S_DONE) && OutReady) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = r_state;
        end
      end
      S_SHIFT: begin
        w_next_data  = w_sh_data;
        w_next_lost  = r_lost | w_sh_lost;
        w_next_rem   = r_rem - w_s_full;
        w_next_state = (r_rem == w_s_full) ? S_DONE : S_SHIFT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (Flush) begin
      w_next_state = S_IDLE;
      w_next_data  = {WIDTH{1'b0}};
      w_next_rem   = {CW{1'b0}};
      w_next_lost  = 1'b0;
    end else begin
      w_next_state = w_next_state;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_data  <= {WIDTH{1'b0}};
      r_rem   <= {CW{1'b0}};
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_data  <= w_next_data;
      r_rem   <= w_next_rem;
      r_lost  <= w_next_lost;
    end
  end

endmodule

// File: tb/tb_normshift.sv
// Directed testbench for normshift (WIDTH=23, STEP=4).
module tb_normshift;

  logic        clk;
  logic        reset_n;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [22:0] InNum;
  logic [4:0]  InShAmt;
  logic        OutValid;
  logic        OutReady;
  logic [22:0] OutNum;
  logic        OutLost;

  int vec_cnt;
  int err_cnt;

  normshift #(.WIDTH(23), .STEP(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .InNum    (InNum),
    .InShAmt  (InShAmt),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutNum   (OutNum),
    .OutLost  (OutLost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [22:0] num, input logic [4:0] sh);
    InNum   = num;
    InShAmt = sh;
    InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!OutValid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume();
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      InValid  = 1'($urandom_range(0, 1));
      OutReady = 1'($urandom_range(0, 1));
      Flush    = 1'($urandom_range(0, 1));
      InNum    = 23'($urandom);
      InShAmt  = 5'($urandom);
      @(posedge clk); #1;
      vec_cnt++;
      if ({OutValid, OutNum, OutLost, InReady} !== {1'b0, 23'h0, 1'b0, 1'b1}) begin
        err_cnt++;
        $display("FAIL reset_hold: got v=%0b num=%h lost=%0b rdy=%0b, want v=0 num=0 lost=0 rdy=1",
                 OutValid, OutNum, OutLost, InReady);
      end
    end
    InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_release: got v=%0b rdy=%0b, want v=0 rdy=1", OutValid, InReady);
    end
  endtask

  task automatic test_full_normalize();
    int n;
    start_op(23'h000001, 5'd22);
    wait_result(n);
    vec_cnt++;
    if (n !== 6) begin
      err_cnt++;
      $display("FAIL full_norm_latency: got %0d, want 6", n);
    end
    vec_cnt++;
    if (OutNum !== 23'h400000 || OutLost !== 1'b0) begin
      err_cnt++;
      $display("FAIL full_norm_result: got %h/%0b, want 400000/0", OutNum, OutLost);
    end
    consume();
    vec_cnt++;
    if (OutValid !== 1'b0) begin
      err_cnt++;
      $display("FAIL full_norm_consume: got v=%0b, want 0", OutValid);
    end
  endtask

  task automatic test_zero_shift();
    int n;
    start_op(23'h012345, 5'd0);
    wait_result(n);
    vec_cnt++;
    if (n !== 0 || OutNum !== 23'h012345 || OutLost !== 1'b0) begin
      err_cnt++;
      $display("FAIL zero_shift: got lat=%0d %h/%0b, want lat=0 012345/0", n, OutNum, OutLost);
    end
    consume();
  endtask

  task automatic test_lost_clamp();
    int n;
    start_op(23'h7FFFFF, 5'd5);
    wait_result(n);
    vec_cnt++;
    if (n !== 2 || OutNum !== 23'h7FFFE0 || OutLost !== 1'b1) begin
      err_cnt++;
      $display("FAIL lost_5: got lat=%0d %h/%0b, want lat=2 7fffe0/1", n, OutNum, OutLost);
    end
    consume();
    start_op(23'h000001, 5'd31);
    wait_result(n);
    vec_cnt++;
    if (n !== 6 || OutNum !== 23'h000000 || OutLost !== 1'b1) begin
      err_cnt++;
      $display("FAIL clamp_31: got lat=%0d %h/%0b, want lat=6 000000/1", n, OutNum, OutLost);
    end
    consume();
    start_op(23'h000003, 5'd21);
    wait_result(n);
    vec_cnt++;
    if (n !== 6 || OutNum !== 23'h600000 || OutLost !== 1'b0) begin
      err_cnt++;
      $display("FAIL edge_21: got lat=%0d %h/%0b, want lat=6 600000/0", n, OutNum, OutLost);
    end
    consume();
  endtask

  task automatic test_backpressure_b2b();
    int n;
    int bad;
    start_op(23'h7FFFFF, 5'd5);
    wait_result(n);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (OutValid !== 1'b1 || OutNum !== 23'h7FFFE0 || OutLost !== 1'b1 || InReady !== 1'b0)
        bad++;
    end
    vec_cnt++;
    if (bad !== 0) begin
      err_cnt++;
      $display("FAIL backpressure_hold: got %0d unstable cycles, want 0", bad);
    end
    OutReady = 1'b1;
    InValid  = 1'b1;
    InNum    = 23'h000100;
    InShAmt  = 5'd8;
    @(posedge clk); #1;
    InValid = 1'b0;
    vec_cnt++;
    if (OutValid !== 1'b0 || InReady !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_capture: got v=%0b rdy=%0b, want v=0 rdy=0", OutValid, InReady);
    end
    wait_result(n);
    vec_cnt++;
    if (n !== 2 || OutNum !== 23'h010000 || OutLost !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_result: got lat=%0d %h/%0b, want lat=2 010000/0", n, OutNum, OutLost);
    end
    @(posedge clk); #1;
    OutReady = 1'b0;
    vec_cnt++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      err_cnt++;
      $display("FAIL b2b_drain: got v=%0b rdy=%0b, want v=0 rdy=1", OutValid, InReady);
    end
  endtask

  task automatic test_zero_throughput();
    logic [22:0] nums [4];
    nums[0] = 23'h000AAA;
    nums[1] = 23'h555555;
    nums[2] = 23'h7FFFFF;
    nums[3] = 23'h123456;
    OutReady = 1'b1;
    InValid  = 1'b1;
    InShAmt  = 5'd0;
    for (int i = 0; i < 4; i++) begin
      InNum = nums[i];
      @(posedge clk); #1;
      vec_cnt++;
      if (OutValid !== 1'b1 || OutNum !== nums[i] || OutLost !== 1'b0) begin
        err_cnt++;
        $display("FAIL zero_tput_%0d: got v=%0b %h/%0b, want v=1 %h/0",
                 i, OutValid, OutNum, OutLost, nums[i]);
      end
    end
    InValid = 1'b0;
    @(posedge clk); #1;
    OutReady = 1'b0;
    vec_cnt++;
    if (OutValid !== 1'b0) begin
      err_cnt++;
      $display("FAIL zero_tput_drain: got v=%0b, want 0", OutValid);
    end
  endtask

  task automatic test_flush();
    int n;
    int pulses;
    start_op(23'h000001, 5'd22);
    @(posedge clk);
    @(posedge clk); #1;
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    vec_cnt++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || OutLost !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_idle: got v=%0b rdy=%0b lost=%0b, want v=0 rdy=1 lost=0",
               OutValid, InReady, OutLost);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (OutValid !== 1'b0) pulses++;
    end
    vec_cnt++;
    if (pulses !== 0) begin
      err_cnt++;
      $display("FAIL flush_no_pulse: got %0d valid cycles, want 0", pulses);
    end
    InNum = 23'h7FFFFF; InShAmt = 5'd0; InValid = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; Flush = 1'b0;
    vec_cnt++;
    if (OutValid !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_no_capture: got v=%0b, want 0", OutValid);
    end
    start_op(23'h000001, 5'd22);
    wait_result(n);
    vec_cnt++;
    if (n !== 6 || OutNum !== 23'h400000 || OutLost !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_recover: got lat=%0d %h/%0b, want lat=6 400000/0", n, OutNum, OutLost);
    end
    consume();
  endtask

  task automatic test_reset_mid_shift();
    int n;
    start_op(23'h7FFFFF, 5'd22);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if ({OutValid, OutNum, OutLost, InReady} !== {1'b0, 23'h0, 1'b0, 1'b1}) begin
      err_cnt++;
      $display("FAIL reset_mid: got v=%0b num=%h lost=%0b rdy=%0b, want v=0 num=0 lost=0 rdy=1",
               OutValid, OutNum, OutLost, InReady);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    start_op(23'h012345, 5'd3);
    wait_result(n);
    vec_cnt++;
    if (n !== 1 || OutNum !== 23'h091A28 || OutLost !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_recover: got lat=%0d %h/%0b, want lat=1 091a28/0", n, OutNum, OutLost);
    end
    consume();
  endtask

  initial begin
    vec_cnt  = 0;
    err_cnt  = 0;
    reset_n  = 1'b0;
    Flush    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    InNum    = 23'h0;
    InShAmt  = 5'd0;
    test_reset();
    test_full_normalize();
    test_zero_shift();
    test_lost_clamp();
    test_backpressure_b2b();
    test_zero_throughput();
    test_flush();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
